// File: rtl/spkr_buffer_fill.sv
// Refills the speaker sample buffer from audio memory, one BURST-sized block per request.
// Build option SPKR_FILL_LOOP_EN: loop the clip at end_addr instead of padding with silence.
module spkr_buffer_fill #(
    parameter int BURST  = 16,
    parameter int ADDR_W = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_addr,
    input  logic [ADDR_W-1:0]        end_addr,
    input  logic                     spkr_update,
    output logic                     buffer_updated,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_valid,
    input  logic [7:0]               mem_data,
    output logic                     buf_wr_en,
    output logic [$clog2(BURST)-1:0] buf_wr_addr,
    output logic [7:0]               buf_wr_data,
    output logic                     play_end
);
    localparam int         IDX_W   = $clog2(BURST);
    localparam logic [7:0] SILENCE = 8'h80;

    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_adv;
    logic [IDX_W-1:0]  idx;
    logic              at_end;
    logic              last_slot;
    logic              skip_read;

    always_comb begin
        at_end    = (ptr == end_addr);
        last_slot = (idx == IDX_W'(BURST - 1));
`ifdef SPKR_FILL_LOOP_EN
        skip_read = 1'b0;
        ptr_adv   = at_end ? start_addr : ptr + ADDR_W'(1);
`else
        // Once the clip end has been played, remaining slots are filled with silence.
        skip_read = play_end;
        ptr_adv   = at_end ? ptr : ptr + ADDR_W'(1);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ptr            <= '0;
            idx            <= '0;
            mem_rd         <= 1'b0;
            mem_addr       <= '0;
            buf_wr_en      <= 1'b0;
            buf_wr_addr    <= '0;
            buf_wr_data    <= '0;
            buffer_updated <= 1'b0;
            play_end       <= 1'b0;
        end else begin
            mem_rd         <= 1'b0;
            buf_wr_en      <= 1'b0;
            buffer_updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= start_addr;
                        play_end <= 1'b0;
                    end else if (spkr_update) begin
                        if (skip_read) begin
                            state       <= WRITE;
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= idx;
                            buf_wr_data <= SILENCE;
                        end else begin
                            state    <= READ;
                            mem_rd   <= 1'b1;
                            mem_addr <= ptr;
                        end
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    if (mem_valid) begin
                        state       <= WRITE;
                        buf_wr_en   <= 1'b1;
                        buf_wr_addr <= idx;
                        buf_wr_data <= mem_data;
                        if (at_end) play_end <= 1'b1;
                    end
                end
                WRITE: begin
                    ptr <= ptr_adv;
`ifdef SPKR_FILL_LOOP_EN
                    play_end <= 1'b0;
`endif
                    if (last_slot) begin
                        state          <= DONE;
                        buffer_updated <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                        if (skip_read) begin
                            buf_wr_en   <= 1'b1;
                            buf_wr_addr <= idx + IDX_W'(1);
                            buf_wr_data <= SILENCE;
                        end else begin
                            state    <= READ;
                            mem_rd   <= 1'b1;
                            mem_addr <= ptr_adv;
                        end
                    end
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spkr_buffer_fill.sv
// Scoreboard bench for spkr_buffer_fill: a clip-level reference model predicts reads and buffer writes.
// Follows SPKR_FILL_LOOP_EN the same way the design does.
module tb_spkr_buffer_fill;
    localparam int BURST  = 16;
    localparam int ADDR_W = 18;
    localparam int LIMIT  = 4000;
`ifdef SPKR_FILL_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              spkr_update;
    logic              buffer_updated;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_valid;
    logic [7:0]        mem_data;
    logic              buf_wr_en;
    logic [3:0]        buf_wr_addr;
    logic [7:0]        buf_wr_data;
    logic              play_end;

    spkr_buffer_fill #(.BURST(BURST), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .spkr_update(spkr_update), .buffer_updated(buffer_updated), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data), .buf_wr_en(buf_wr_en),
        .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .play_end(play_end)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Expected streams
    int                exp_idx[$];
    int                exp_data[$];
    int                exp_pe[$];
    logic [ADDR_W-1:0] exp_rd[$];
    int                exp_done[$];
    int                pushed      = 0;
    int                writes_seen = 0;
    int                reads_seen  = 0;
    int                mem_delay   = 0;

    // Clip-level model state
    logic [ADDR_W-1:0] ptr_m;
    logic [ADDR_W-1:0] start_m;
    logic [ADDR_W-1:0] end_m;
    bit                pe_m;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen with nothing expected at %0t", name, $time);
    endfunction

    // One refill of BURST samples; returns cycle count from request to buffer_updated for fixed delay d.
    task automatic model_refill(input int d, output int lat);
        bit   rd;
        bit   at_end;
        int   data;
        int   pe_out;
        lat = 1;
        for (int i = 0; i < BURST; i++) begin
            rd = LOOP || !pe_m;
            if (rd) begin
                exp_rd.push_back(ptr_m);
                data = int'(ptr_m[7:0]);
                lat += 3 + d;
            end else begin
                data = 8'h80;
                lat += 1;
            end
            at_end = (ptr_m == end_m);
            if (LOOP) begin
                pe_out = int'(at_end);
                ptr_m  = at_end ? start_m : ptr_m + 1;
            end else begin
                if (at_end) pe_m = 1'b1;
                else        ptr_m = ptr_m + 1;
                pe_out = int'(pe_m);
            end
            exp_idx.push_back(i);
            exp_data.push_back(data);
            exp_pe.push_back(pe_out);
        end
        pushed += BURST;
        exp_done.push_back(pushed);
    endtask

    // Monitor: pops expectations whenever the DUT presents a read, a buffer write or a completion.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_rd) begin
                    reads_seen++;
                    if (exp_rd.size() == 0) fail_event("unexpected_mem_rd");
                    else chk("mem_rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
                end
                if (buf_wr_en) begin
                    writes_seen++;
                    if (exp_idx.size() == 0) fail_event("unexpected_buf_write");
                    else begin
                        chk("buf_wr_addr", 32'(buf_wr_addr), exp_idx.pop_front());
                        chk("buf_wr_data", 32'(buf_wr_data), exp_data.pop_front());
                        chk("play_end_at_write", 32'(play_end), exp_pe.pop_front());
                    end
                end
                if (buffer_updated) begin
                    if (exp_done.size() == 0) fail_event("unexpected_buffer_updated");
                    else chk("writes_at_done", writes_seen, exp_done.pop_front());
                end
            end
        end
    end

    // Memory: answers each read after mem_delay extra cycles with data = addr[7:0];
    // sometimes keeps mem_valid up one extra cycle with junk data, which must be ignored.
    initial begin
        int                cd = -1;
        bit                tail = 1'b0;
        logic [ADDR_W-1:0] held = '0;
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (rst) begin
                cd   = -1;
                tail = 1'b0;
            end else begin
                if (tail) begin
                    mem_valid = 1'b1;
                    mem_data  = 8'($urandom);
                    tail      = 1'b0;
                end else if (cd == 0) begin
                    chk("mem_addr_held", 32'(mem_addr), 32'(held));
                    mem_valid = 1'b1;
                    mem_data  = mem_addr[7:0];
                    tail      = ($urandom_range(0, 1) == 1);
                    cd        = -1;
                end else if (cd > 0) begin
                    chk("mem_addr_held", 32'(mem_addr), 32'(held));
                    cd--;
                end
                if (mem_rd) begin
                    held = mem_addr;
                    cd   = (mem_delay < 0) ? int'($urandom_range(0, 6)) : mem_delay;
                end
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        start_m = s;
        end_m   = e;
        ptr_m   = s;
        pe_m    = 1'b0;
    endtask

    // n back-to-back refills; d<0 means random memory delay (latency not checked then).
    task automatic run_refills(input int n, input int d, input bit with_start, input int mid_start);
        int lat;
        int lat0 = 0;
        int cyc  = 0;
        int seen = 0;
        mem_delay = d;
        if (with_start) begin
            start_m = start_addr;
            end_m   = end_addr;
            ptr_m   = start_addr;
            pe_m    = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            model_refill((d < 0) ? 0 : d, lat);
            if (k == 0) lat0 = lat + int'(with_start);
        end
        start       = with_start;
        spkr_update = 1'b1;
        while (seen < n && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (with_start && cyc == 1) chk("start_priority_no_rd", 32'(mem_rd), 0);
            start = (mid_start > 0 && cyc == mid_start);
            if (buffer_updated) begin
                seen++;
                if (seen == 1 && d >= 0) chk("refill_latency", cyc, lat0);
                if (seen == n) spkr_update = 1'b0;
            end
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL refill_timeout: got %0d completions expected %0d", seen, n);
            spkr_update = 1'b0;
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_buf_wr_en"}, 32'(buf_wr_en), 0);
        chk({tag, "_buf_wr_addr"}, 32'(buf_wr_addr), 0);
        chk({tag, "_buf_wr_data"}, 32'(buf_wr_data), 0);
        chk({tag, "_buffer_updated"}, 32'(buffer_updated), 0);
        chk({tag, "_play_end"}, 32'(play_end), 0);
    endtask

    task automatic reset_mid_refill();
        int lat;
        int cyc = 0;
        int wb  = writes_seen;
        int rb  = reads_seen;
        mem_delay = 5;
        model_refill(5, lat);
        spkr_update = 1'b1;
        while (!(writes_seen >= wb + 5 && reads_seen >= rb + 6) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL reach_idx5_wait: got %0d writes expected %0d", writes_seen - wb, 5);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst_async");
        repeat (3) @(negedge clk);
        exp_idx.delete();
        exp_data.delete();
        exp_pe.delete();
        exp_rd.delete();
        exp_done.delete();
        pushed = writes_seen;
        ptr_m  = '0;
        pe_m   = 1'b0;
        rst    = 1'b0;
        run_refills(1, 5, 1'b0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] e;
        rst         = 1'b0;
        start       = 1'b0;
        spkr_update = 1'b0;
        start_addr  = '0;
        end_addr    = '0;
        start_m     = '0;
        end_m       = '0;
        ptr_m       = '0;
        pe_m        = 1'b0;
        #2 rst = 1'b1;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-cycle memory, then 5-cycle memory over the same clip start
        do_start(18'h100, 18'h1FF);
        run_refills(1, 0, 1'b0, 0);
        do_start(18'h100, 18'h1FF);
        run_refills(1, 5, 1'b0, 0);

        // Short clip: end reached mid-burst, then a back-to-back second refill
        do_start(18'h100, 18'h107);
        run_refills(2, 0, 1'b0, 0);

        // start and spkr_update together in IDLE
        start_addr = 18'h100;
        end_addr   = 18'h1FF;
        run_refills(1, 0, 1'b1, 0);

        // Randomized clips, delays, burst counts and ignored mid-refill start pulses
        for (int t = 0; t < 6; t++) begin
            s = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 64));
            e = s + ADDR_W'($urandom_range(0, 40));
            if (t == 5) begin
                e = '1;
                s = e - ADDR_W'($urandom_range(0, 20));
            end
            do_start(s, e);
            run_refills(int'($urandom_range(1, 3)), (t % 2 == 1) ? -1 : int'($urandom_range(0, 3)),
                        1'b0, (t % 3 == 0) ? 10 : 0);
        end

        // Asynchronous reset while waiting on memory at idx 5
        do_start(18'h100, 18'h1FF);
        reset_mid_refill();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
